// File: rtl/pll_phase_pkg.sv
// Shared types and defaults for the PLL dynamic phase-shift responder.
package pll_phase_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] SEL_ALL = 3'b111;

  localparam int DEF_NUM_CNT  = 5;
  localparam int DEF_TAP_W    = 3;
  localparam int DEF_BUSY_CYC = 4;
  localparam int DEF_LOCK_CYC = 16;

  // A select is usable if it names an existing counter or broadcasts to all of them.
  function automatic logic sel_legal(input logic [2:0] sel, input int num_cnt);
    return (int'(sel) < num_cnt) || (sel == SEL_ALL);
  endfunction

endpackage

// File: rtl/pll_phase_responder_if.sv
// Controller-to-PLL phase-shift bus: master is the phase-shift controller, slave the responder.
interface pll_phase_responder_if
  import pll_phase_pkg::*;
#(
  parameter int NUM_CNT = DEF_NUM_CNT,
  parameter int TAP_W   = DEF_TAP_W
);

  // A rising edge on phasestep is the request (valid); phasedone high means the
  // responder can take the next request (ready). A controller raises phasestep only
  // after it has seen phasedone=1; edges seen while busy or unlocked pulse step_err.
  logic                     pll_en;
  logic                     phasestep;
  logic                     phaseupdown;
  logic [2:0]               phasecounterselect;
  logic                     phasedone;
  logic                     pll_lock;
  logic [NUM_CNT*TAP_W-1:0] phase_taps;
  logic                     step_err;

  modport master (
    output pll_en, phasestep, phaseupdown, phasecounterselect,
    input  phasedone, pll_lock, phase_taps, step_err
  );

  modport slave (
    input  pll_en, phasestep, phaseupdown, phasecounterselect,
    output phasedone, pll_lock, phase_taps, step_err
  );

endinterface

// File: rtl/pll_phase_responder_lock_timer.sv
// Lock timer: pll_lock rises LOCK_CYC+1 edges after pll_en goes high; pll_en low unlocks.
module pll_lock_timer
  import pll_phase_pkg::*;
#(
  parameter int LOCK_CYC = DEF_LOCK_CYC
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic pll_en,
  output logic pll_lock
);

  localparam int CW = $clog2(LOCK_CYC + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CYC);

  logic [CW-1:0] cnt_q;

  // The counter parks at LOCK_CYC; one more edge then declares lock.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      pll_lock <= 1'b0;
    end else if (!pll_en) begin
      cnt_q    <= '0;
      pll_lock <= 1'b0;
    end else if (!pll_lock) begin
      if (cnt_q == LOCK_MAX) begin
        pll_lock <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_phase_responder.sv
// PLL dynamic phase-shift responder: per-counter tap bank stepped through a
// phasestep/phasedone handshake, gated by a lock timer.
module pll_phase_responder
  import pll_phase_pkg::*;
#(
  parameter int NUM_CNT  = DEF_NUM_CNT,
  parameter int TAP_W    = DEF_TAP_W,
  parameter int BUSY_CYC = DEF_BUSY_CYC,
  parameter int LOCK_CYC = DEF_LOCK_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  pll_phase_responder_if.slave  bus
);

  localparam int BW = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;

  state_t           state_q, state_d;
  logic [BW-1:0]    busy_q, busy_d;
  logic [2:0]       sel_q, sel_d;
  logic             dir_q, dir_d;
  logic             ps_q;
  logic             step_err_q, step_err_d;
  logic [TAP_W-1:0] taps_q [NUM_CNT];
  logic [TAP_W-1:0] taps_d [NUM_CNT];
  logic             pll_lock;
  logic             req;
  logic             accept;

  pll_lock_timer #(
    .LOCK_CYC (LOCK_CYC)
  ) u_lock_timer (
    .clk      (clk),
    .rst_n_i  (rst_n_i),
    .pll_en   (bus.pll_en),
    .pll_lock (pll_lock)
  );

  always_comb begin
    req        = bus.phasestep & ~ps_q;
    accept     = 1'b0;
    state_d    = state_q;
    busy_d     = busy_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    taps_d     = taps_q;
    case (state_q)
      ST_IDLE: begin
        // pll_en is checked directly: lock only drops one edge after pll_en does.
        if (req && pll_lock && bus.pll_en &&
            sel_legal(bus.phasecounterselect, NUM_CNT)) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
          busy_d  = BW'(BUSY_CYC - 1);
          sel_d   = bus.phasecounterselect;
          dir_d   = bus.phaseupdown;
        end
      end
      ST_BUSY: begin
        if (!bus.pll_en) begin
          state_d = ST_IDLE;
        end else if (busy_q == '0) begin
          state_d = ST_IDLE;
          for (int k = 0; k < NUM_CNT; k++) begin
            if (sel_q == SEL_ALL || sel_q == 3'(k)) begin
              taps_d[k] = dir_q ? taps_q[k] + 1'b1 : taps_q[k] - 1'b1;
            end
          end
        end else begin
          busy_d = busy_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    step_err_d = req & ~accept;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      busy_q     <= '0;
      sel_q      <= '0;
      dir_q      <= 1'b0;
      ps_q       <= 1'b0;
      step_err_q <= 1'b0;
      for (int k = 0; k < NUM_CNT; k++) begin
        taps_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      ps_q       <= bus.phasestep;
      step_err_q <= step_err_d;
      for (int k = 0; k < NUM_CNT; k++) begin
        taps_q[k] <= taps_d[k];
      end
    end
  end

  // Taps update on the same edge that returns to IDLE, so they change as phasedone rises.
  always_comb begin
    bus.phase_taps = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      bus.phase_taps[k*TAP_W +: TAP_W] = taps_q[k];
    end
  end

  assign bus.phasedone = (state_q == ST_IDLE);
  assign bus.pll_lock  = pll_lock;
  assign bus.step_err  = step_err_q;

endmodule

// File: tb/tb_pll_phase_responder.sv
// Bench for pll_phase_responder: directed handshake scenarios plus random steps
// checked against a modulo-arithmetic tap model.
module tb_pll_phase_responder;

  localparam int NUM_CNT  = 5;
  localparam int TAP_W    = 3;
  localparam int BUSY_CYC = 4;
  localparam int LOCK_CYC = 16;
  localparam int TAP_MOD  = 1 << TAP_W;

  logic clk;
  logic rst_n_i;

  int compared   = 0;
  int mismatched = 0;

  int model_taps [NUM_CNT];
  bit model_locked;

  pll_phase_responder_if #(.NUM_CNT(NUM_CNT), .TAP_W(TAP_W)) bus ();

  pll_phase_responder #(
    .NUM_CNT  (NUM_CNT),
    .TAP_W    (TAP_W),
    .BUSY_CYC (BUSY_CYC),
    .LOCK_CYC (LOCK_CYC)
  ) dut (
    .clk     (clk),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CNT*TAP_W-1:0] model_pack();
    logic [NUM_CNT*TAP_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CNT; k++) v[k*TAP_W +: TAP_W] = TAP_W'(model_taps[k]);
    return v;
  endfunction

  function automatic bit legal(input logic [2:0] sel);
    return (int'(sel) < NUM_CNT) || (sel == 3'b111);
  endfunction

  task automatic model_apply(input logic [2:0] sel, input logic dir);
    for (int k = 0; k < NUM_CNT; k++) begin
      if (sel == 3'b111 || int'(sel) == k)
        model_taps[k] = (model_taps[k] + (dir ? 1 : -1) + TAP_MOD) % TAP_MOD;
    end
  endtask

  // pll_en is raised just after an edge; lock must appear after exactly LOCK_CYC+1 edges.
  task automatic wait_lock(input string tag);
    int n   = 0;
    int bad = 0;
    bus.pll_en = 1'b1;
    while (bus.pll_lock !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (bus.phasedone !== 1'b1 || bus.phase_taps !== model_pack()) bad++;
    end
    check({tag, "_edges"}, n, LOCK_CYC + 1);
    check({tag, "_quiet"}, bad, 0);
    model_locked = 1'b1;
  endtask

  task automatic run_step(input string tag, input logic [2:0] sel, input logic dir, input int hold);
    bit exp_acc;
    int low;
    int cyc;
    int err_seen;
    exp_acc = model_locked && legal(sel);
    bus.phasecounterselect = sel;
    bus.phaseupdown        = dir;
    bus.phasestep          = 1'b1;
    tick();
    if (exp_acc) begin
      check({tag, "_drop"}, bus.phasedone, 1'b0);
      low = 1; cyc = 1; err_seen = bus.step_err;
      while (bus.phasedone === 1'b0 && low < 30) begin
        if (cyc >= hold) bus.phasestep = 1'b0;
        cyc++;
        tick();
        if (bus.phasedone === 1'b0) low++;
        if (bus.step_err === 1'b1) err_seen++;
      end
      model_apply(sel, dir);
      check({tag, "_low"}, low, BUSY_CYC);
      check({tag, "_taps"}, bus.phase_taps, model_pack());
      check({tag, "_noerr"}, err_seen, 0);
    end else begin
      check({tag, "_err"}, bus.step_err, 1'b1);
      check({tag, "_rej_done"}, bus.phasedone, 1'b1);
      bus.phasestep = 1'b0;
      tick();
      check({tag, "_err_clr"}, bus.step_err, 1'b0);
      check({tag, "_rej_taps"}, bus.phase_taps, model_pack());
    end
    bus.phasestep = 1'b0;
    tick();
  endtask

  initial begin
    int low;
    rst_n_i                = 1'b0;
    bus.pll_en             = 1'b0;
    bus.phasestep          = 1'b0;
    bus.phaseupdown        = 1'b0;
    bus.phasecounterselect = 3'd0;
    model_locked           = 1'b0;
    for (int k = 0; k < NUM_CNT; k++) model_taps[k] = 0;

    #3;
    check("rst_phasedone", bus.phasedone, 1'b1);
    check("rst_lock", bus.pll_lock, 1'b0);
    check("rst_taps", bus.phase_taps, '0);
    check("rst_err", bus.step_err, 1'b0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();

    // Request while unlocked is rejected.
    run_step("unlocked", 3'd0, 1'b1, 1);
    wait_lock("lock");

    run_step("sel2_up", 3'd2, 1'b1, 3);
    run_step("sel0_dn", 3'd0, 1'b0, 1);
    check("wrap_dn", bus.phase_taps[2:0], 3'd7);
    run_step("sel0_up", 3'd0, 1'b1, 1);
    check("wrap_up", bus.phase_taps[2:0], 3'd0);
    run_step("all_up", 3'b111, 1'b1, 2);
    run_step("sel5", 3'd5, 1'b1, 1);
    run_step("sel6", 3'd6, 1'b0, 1);

    // Second edge two cycles into BUSY: rejected, the first step finishes untouched.
    bus.phasecounterselect = 3'd3;
    bus.phaseupdown        = 1'b1;
    bus.phasestep          = 1'b1;
    tick();
    bus.phasestep = 1'b0;
    tick();
    bus.phasestep = 1'b1;
    tick();
    check("coll_err", bus.step_err, 1'b1);
    check("coll_busy", bus.phasedone, 1'b0);
    bus.phasestep = 1'b0;
    low = 3;
    for (int i = 0; i < 30 && bus.phasedone === 1'b0; i++) begin
      tick();
      if (bus.phasedone === 1'b0) low++;
    end
    model_apply(3'd3, 1'b1);
    check("coll_low", low, BUSY_CYC);
    check("coll_taps", bus.phase_taps, model_pack());
    tick();

    // pll_en dropped on the second BUSY cycle aborts the step.
    bus.phasecounterselect = 3'd1;
    bus.phaseupdown        = 1'b1;
    bus.phasestep          = 1'b1;
    tick();
    bus.phasestep = 1'b0;
    tick();
    bus.pll_en   = 1'b0;
    model_locked = 1'b0;
    tick();
    check("abort_done", bus.phasedone, 1'b1);
    check("abort_lock", bus.pll_lock, 1'b0);
    check("abort_taps", bus.phase_taps, model_pack());
    tick(); tick();
    check("abort_hold", bus.phase_taps, model_pack());
    wait_lock("relock1");
    run_step("after_relock", 3'd1, 1'b1, 1);

    // Request edge in the same cycle pll_en falls.
    bus.phasecounterselect = 3'd4;
    bus.phaseupdown        = 1'b0;
    bus.phasestep          = 1'b1;
    bus.pll_en             = 1'b0;
    model_locked           = 1'b0;
    tick();
    check("en_drop_err", bus.step_err, 1'b1);
    check("en_drop_done", bus.phasedone, 1'b1);
    bus.phasestep = 1'b0;
    wait_lock("relock2");
    check("en_drop_taps", bus.phase_taps, model_pack());

    for (int i = 0; i < 24; i++) begin
      run_step("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
